fifo: RTL and testbench
=======================

// Module: fifo
// PURPOSE
//   Single-clock synchronous FIFO buffering DATA_WIDTH-bit words, DEPTH entries deep.
//   Decouples a producer and a consumer in the same clock domain using level-style
//   enables and full/empty status flags. Circular buffer with read/write pointers.
// PARAMETERS
//   DATA_WIDTH  32  width of each stored word
//   DEPTH       16  number of entries; power of two, >= 2
// PORTS
//   clk      in   1           single clock; all state changes on rising edge
//   reset    in   1           asynchronous, active-high reset
//   wr_en    in   1           write request, sampled at rising clk
//   wr_data  in   DATA_WIDTH  data written when a write is accepted
//   rd_en    in   1           read request, sampled at rising clk
//   rd_data  out  DATA_WIDTH  registered read data
//   full     out  1           high when DEPTH entries stored
//   empty    out  1           high when 0 entries stored
//   count    out  $clog2(DEPTH)+1  occupancy (only with FIFO_COUNT_EN)
// BEHAVIOUR
//   - Reset (async assert, sync release): pointers=0, occupancy=0, empty=1, full=0,
//     rd_data=0, count=0. Storage contents need not be cleared. Reset mid-operation
//     discards all stored data immediately.
//   - Write accepted iff wr_en && !full: mem[wr_ptr]<=wr_data; wr_ptr++ mod DEPTH.
//   - Read accepted iff rd_en && !empty: rd_data<=mem[rd_ptr]; rd_ptr++ mod DEPTH.
//     Latency 1 cycle: rd_data valid after the edge that accepts the read; holds its
//     value otherwise (including ignored reads).
//   - Write when full: ignored, no state change. Read when empty: ignored, rd_data holds.
//   - Simultaneous wr_en & rd_en: each judged on pre-edge flags. Neither full nor empty:
//     both occur, occupancy unchanged. Empty: write only (no fall-through). Full: read
//     only, write dropped.
//   - Flags registered/derived from occupancy after the edge: empty = (occ==0),
//     full = (occ==DEPTH). No combinational path from wr_en/rd_en to flags.
//   - Pointers wrap DEPTH-1 -> 0; order strictly first-in first-out across wrap.
//   - Occupancy tracked with $clog2(DEPTH)+1-bit counter (or extra pointer MSB).
// CONFIGURATION
//   FIFO_COUNT_EN defined: count port present, equals current occupancy (0..DEPTH),
//     reset 0, updated on same edge as flags.
//   FIFO_COUNT_EN undefined: count port and its logic absent; all other behaviour identical.
// TESTING
//   1 Reset: assert reset mid-run -> empty=1, full=0, rd_data=0 immediately, no clk needed.
//   2 Write 4 words A,B,C,D; read 2 -> rd_data=A then B on successive edges; empty=0;
//     count=2. Write E,F,G; drain -> C,D,E,F,G in order, then empty=1, count=0.
//   3 Write 16 words 0..15 -> full=1 after 16th; 17th write (0xDEAD) dropped; drain
//     returns 0..15 exactly, never 0xDEAD.
//   4 Read on empty FIFO -> rd_data unchanged, empty stays 1, pointers unmoved.
//   5 Simultaneous wr_en/rd_en with 3 entries for 20 cycles -> count stays 3, data
//     order preserved through pointer wrap; on full, simultaneous op yields read only.
//   6 Build with and without FIFO_COUNT_EN -> identical rd_data/full/empty traces.

Source files
------------

// File: rtl/fifo.sv
// Single-clock synchronous FIFO: circular buffer with registered read data and flags.
// Optional occupancy output enabled by defining FIFO_COUNT_EN.
`timescale 1ns/1ps
module fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
`ifdef FIFO_COUNT_EN
   ,output logic [$clog2(DEPTH):0] count
`endif
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      occ_q, occ_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  wr_ok, rd_ok;

   // Acceptance is judged on the registered flags, so enables never reach the flags combinationally.
   always_comb begin
      wr_ok     = wr_en && !full_q;
      rd_ok     = rd_en && !empty_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      rd_data_d = rd_data_q;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_ok) begin
         rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
         rd_data_d = mem[rd_ptr_q];
      end

      unique case ({wr_ok, rd_ok})
         2'b10:   occ_d = occ_q + CNT_W'(1);
         2'b01:   occ_d = occ_q - CNT_W'(1);
         default: occ_d = occ_q;
      endcase

      full_d  = (occ_d == CNT_W'(DEPTH));
      empty_d = (occ_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = rd_data_q;
   assign full    = full_q;
   assign empty   = empty_q;
`ifdef FIFO_COUNT_EN
   assign count   = occ_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo (DEPTH 16, 32-bit words).
// Occupancy checks are compiled in only when FIFO_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_fifo;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        full;
   logic        empty;
`ifdef FIFO_COUNT_EN
   logic [4:0]  count;
`endif

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   fifo #(.DATA_WIDTH(32), .DEPTH(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty)
`ifdef FIFO_COUNT_EN
      ,.count  (count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input int unsigned exp);
`ifdef FIFO_COUNT_EN
      chk(tag, {27'd0, count}, exp);
`else
      chk(tag, {31'd0, empty}, (exp == 0) ? 32'd1 : 32'd0);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic w, input logic r, input logic [31:0] d);
      wr_en   = w;
      rd_en   = r;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      #3;
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk_cnt("rst_count", 0);
      tick();
      tick();
      reset = 1'b0;

      // Basic ordering
      op(1, 0, 32'hAAAA_0001);
      op(1, 0, 32'hAAAA_0002);
      op(1, 0, 32'hAAAA_0003);
      op(1, 0, 32'hAAAA_0004);
      op(0, 1, '0);
      chk("rd_A", rd_data, 32'hAAAA_0001);
      op(0, 1, '0);
      chk("rd_B", rd_data, 32'hAAAA_0002);
      chk("two_left_empty", {31'd0, empty}, 32'd0);
      chk_cnt("two_left_count", 2);
      op(1, 0, 32'hAAAA_0005);
      op(1, 0, 32'hAAAA_0006);
      op(1, 0, 32'hAAAA_0007);
      for (int i = 3; i <= 7; i++) begin
         op(0, 1, '0);
         chk("drain_CG", rd_data, 32'hAAAA_0000 + 32'(i));
      end
      chk("drained_empty", {31'd0, empty}, 32'd1);
      chk_cnt("drained_count", 0);

      // Read on empty is ignored
      op(0, 1, '0);
      chk("empty_rd_hold", rd_data, 32'hAAAA_0007);
      chk("empty_rd_empty", {31'd0, empty}, 32'd1);
      op(1, 0, 32'h0000_1234);
      op(0, 1, '0);
      chk("ptr_unmoved", rd_data, 32'h0000_1234);

      // Fill to full, overflow write dropped
      for (int i = 0; i < 16; i++) begin
         op(1, 0, 32'(i));
         if (i == 14) chk("full_at_15", {31'd0, full}, 32'd0);
      end
      chk("full_at_16", {31'd0, full}, 32'd1);
      chk_cnt("count_16", 16);
      op(1, 0, 32'h0000_DEAD);
      chk("full_after_ovf", {31'd0, full}, 32'd1);
      chk_cnt("count_after_ovf", 16);
      for (int i = 0; i < 16; i++) begin
         op(0, 1, '0);
         chk("drain_full", rd_data, 32'(i));
         if (i == 0) chk("full_clears", {31'd0, full}, 32'd0);
      end
      chk("after_full_empty", {31'd0, empty}, 32'd1);
      op(0, 1, '0);
      chk("no_dead", rd_data, 32'd15);

      // Simultaneous ops in steady state, across pointer wrap
      op(1, 0, 32'd100);
      op(1, 0, 32'd101);
      op(1, 0, 32'd102);
      for (int i = 0; i < 20; i++) begin
         op(1, 1, 32'd103 + 32'(i));
         chk("simul_data", rd_data, 32'd100 + 32'(i));
         chk_cnt("simul_count", 3);
      end
      for (int i = 20; i < 23; i++) begin
         op(0, 1, '0);
         chk("simul_drain", rd_data, 32'd100 + 32'(i));
      end
      chk("simul_empty", {31'd0, empty}, 32'd1);

      // Simultaneous on empty: write only
      op(1, 1, 32'h0000_0077);
      chk("se_rd_hold", rd_data, 32'd122);
      chk("se_not_empty", {31'd0, empty}, 32'd0);
      chk_cnt("se_count", 1);
      op(0, 1, '0);
      chk("se_data", rd_data, 32'h0000_0077);

      // Simultaneous on full: read only
      for (int i = 0; i < 16; i++) op(1, 0, 32'd200 + 32'(i));
      op(1, 1, 32'h0000_DEAD);
      chk("sf_rd", rd_data, 32'd200);
      chk("sf_not_full", {31'd0, full}, 32'd0);
      chk_cnt("sf_count", 15);
      for (int i = 1; i < 16; i++) begin
         op(0, 1, '0);
         chk("sf_drain", rd_data, 32'd200 + 32'(i));
      end
      chk("sf_empty", {31'd0, empty}, 32'd1);

      // Asynchronous reset mid-run
      op(1, 0, 32'h0000_0A01);
      op(1, 0, 32'h0000_0A02);
      op(0, 1, '0);
      chk("pre_rst_rd", rd_data, 32'h0000_0A01);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_empty", {31'd0, empty}, 32'd1);
      chk("mid_rst_full", {31'd0, full}, 32'd0);
      chk("mid_rst_rd_data", rd_data, 32'd0);
      chk_cnt("mid_rst_count", 0);
      tick();
      reset = 1'b0;
      op(0, 1, '0);
      chk("post_rst_rd_hold", rd_data, 32'd0);
      chk("post_rst_empty", {31'd0, empty}, 32'd1);
      op(1, 0, 32'h0000_0B01);
      op(0, 1, '0);
      chk("post_rst_data", rd_data, 32'h0000_0B01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
